soc_addr_map_unit: RTL and testbench

Runtime-programmable SoC address-map and region-attribute unit. Holds `NrRules` address rules (base, length, target index, cached/executable/idempotent attributes) that reset to the standard SoC map. Answers pipelined lookups from the core/crossbar side with a valid/ready handshake. It supersedes the fixed compile-time map constants: rules can be rewritten at boot through a config write port, and illegal accesses are flagged.

---
 rtl/soc_addr_map_unit.sv | 200 ++++++++++++++++++++
 tb/tb_soc_addr_map_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_addr_map_unit.sv
// Programmable SoC address map: NrRules base/length/attr rules with a one-stage
// registered lookup pipeline and a boot-time config write port. Optional macro: SOC_AMU_LOCK_EN.
module soc_addr_map_unit #(
  parameter int unsigned NrRules   = 10,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = $clog2(NrRules)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [1:0]           req_kind_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [IdxWidth-1:0]  resp_idx_o,
  output logic                 resp_cached_o,
  output logic                 resp_exec_o,
  output logic                 resp_idem_o,
  output logic                 resp_err_o,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_err_o
);

  typedef logic [AddrWidth-1:0] addr_t;

  function automatic addr_t rst_base(input int unsigned i);
    case (i)
      0:       rst_base = addr_t'(64'h8000_0000);
      1:       rst_base = addr_t'(64'h4000_0000);
      2:       rst_base = addr_t'(64'h3000_0000);
      3:       rst_base = addr_t'(64'h2000_0000);
      4:       rst_base = addr_t'(64'h1800_0000);
      5:       rst_base = addr_t'(64'h1000_0000);
      6:       rst_base = addr_t'(64'h0C00_0000);
      7:       rst_base = addr_t'(64'h0200_0000);
      8:       rst_base = addr_t'(64'h0001_0000);
      default: rst_base = '0;
    endcase
  endfunction

  function automatic addr_t rst_len(input int unsigned i);
    case (i)
      0:       rst_len = addr_t'(64'h4000_0000);
      1:       rst_len = addr_t'(64'h1000);
      2:       rst_len = addr_t'(64'h1_0000);
      3:       rst_len = addr_t'(64'h80_0000);
      4:       rst_len = addr_t'(64'h1000);
      5:       rst_len = addr_t'(64'h1000);
      6:       rst_len = addr_t'(64'h3FF_FFFF);
      7:       rst_len = addr_t'(64'hC_0000);
      8:       rst_len = addr_t'(64'h1_0000);
      9:       rst_len = addr_t'(64'h1000);
      default: rst_len = '0;
    endcase
  endfunction

  // attr layout: [0] valid, [1] cached, [2] exec, [3] idem, [4] lock
  function automatic logic [4:0] rst_attr(input int unsigned i);
    case (i)
      0:                   rst_attr = 5'b01111;
      1, 2, 3, 4, 5, 6, 7: rst_attr = 5'b00001;
      8, 9:                rst_attr = 5'b00101;
      default:             rst_attr = 5'b00000;
    endcase
  endfunction

  addr_t      base_q [NrRules];
  addr_t      base_d [NrRules];
  addr_t      len_q  [NrRules];
  addr_t      len_d  [NrRules];
  logic [4:0] attr_q [NrRules];
  logic [4:0] attr_d [NrRules];

  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [IdxWidth-1:0] resp_idx_q, resp_idx_d;
  logic [2:0]          resp_attr_q, resp_attr_d;
  logic                resp_err_q, resp_err_d;
  logic                cfg_err_q, cfg_err_d;

  logic                req_accept;
  logic                lu_hit;
  logic [IdxWidth-1:0] lu_idx;
  logic [4:0]          lu_attr;
  addr_t               diff;
  logic                cfg_in_range, cfg_locked, cfg_reject, cfg_write;
  logic [4:0]          attr_wr;

  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;

  // Scan from the top index down so the lowest matching index is the last assignment.
  always_comb begin
    lu_hit  = 1'b0;
    lu_idx  = '0;
    lu_attr = '0;
    diff    = '0;
    for (int i = int'(NrRules) - 1; i >= 0; i--) begin
      diff = req_addr_i - base_q[i];
      if (attr_q[i][0] && (len_q[i] != '0) && (diff < len_q[i])) begin
        lu_hit  = 1'b1;
        lu_idx  = IdxWidth'(i);
        lu_attr = attr_q[i];
      end
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    resp_idx_d   = resp_idx_q;
    resp_attr_d  = resp_attr_q;
    resp_err_d   = resp_err_q;
    if (req_accept) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = lu_hit;
      resp_idx_d   = lu_idx;
      resp_attr_d  = {lu_attr[1], lu_attr[2], lu_attr[3]};
      resp_err_d   = !lu_hit || ((req_kind_i == 2'd2) && !lu_attr[2]);
    end else if (resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  // Lock bit is only ever stored as 1 when locking is compiled in.
  always_comb begin
    cfg_in_range = 1'b0;
    cfg_locked   = 1'b0;
    for (int i = 0; i < int'(NrRules); i++) begin
      if (cfg_idx_i == IdxWidth'(i)) begin
        cfg_in_range = 1'b1;
        cfg_locked   = attr_q[i][4];
      end
    end
`ifdef SOC_AMU_LOCK_EN
    attr_wr = cfg_wdata_i[4:0];
`else
    attr_wr = {1'b0, cfg_wdata_i[3:0]};
`endif
    cfg_reject = cfg_we_i && (!cfg_in_range || (cfg_field_i == 2'd3) || cfg_locked);
    cfg_write  = cfg_we_i && !cfg_reject;
    cfg_err_d  = cfg_reject;
    for (int i = 0; i < int'(NrRules); i++) begin
      base_d[i] = base_q[i];
      len_d[i]  = len_q[i];
      attr_d[i] = attr_q[i];
      if (cfg_write && (cfg_idx_i == IdxWidth'(i))) begin
        case (cfg_field_i)
          2'd0:    base_d[i] = cfg_wdata_i;
          2'd1:    len_d[i]  = cfg_wdata_i;
          2'd2:    attr_d[i] = attr_wr;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        base_q[i] <= rst_base(i);
        len_q[i]  <= rst_len(i);
        attr_q[i] <= rst_attr(i);
      end
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
      resp_attr_q  <= '0;
      resp_err_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NrRules); i++) begin
        base_q[i] <= base_d[i];
        len_q[i]  <= len_d[i];
        attr_q[i] <= attr_d[i];
      end
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_idx_q   <= resp_idx_d;
      resp_attr_q  <= resp_attr_d;
      resp_err_q   <= resp_err_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_hit_o    = resp_hit_q;
  assign resp_idx_o    = resp_idx_q;
  assign resp_cached_o = resp_attr_q[2];
  assign resp_exec_o   = resp_attr_q[1];
  assign resp_idem_o   = resp_attr_q[0];
  assign resp_err_o    = resp_err_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// Bench for soc_addr_map_unit: directed map scenarios plus random lookups/config writes,
// checked against a rule-table reference model through an expected-response queue.
module tb_soc_addr_map_unit;

  localparam int NR = 12;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int W  = 9;
`ifdef SOC_AMU_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i, req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [1:0]    req_kind_i;
  logic          resp_valid_o, resp_ready_i, resp_hit_o;
  logic [IW-1:0] resp_idx_o;
  logic          resp_cached_o, resp_exec_o, resp_idem_o, resp_err_o;
  logic          cfg_we_i;
  logic [IW-1:0] cfg_idx_i;
  logic [1:0]    cfg_field_i;
  logic [AW-1:0] cfg_wdata_i;
  logic          cfg_err_o;

  soc_addr_map_unit #(.NrRules(NR), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_kind_i(req_kind_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_hit_o(resp_hit_o), .resp_idx_o(resp_idx_o),
    .resp_cached_o(resp_cached_o), .resp_exec_o(resp_exec_o),
    .resp_idem_o(resp_idem_o), .resp_err_o(resp_err_o),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_field_i(cfg_field_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  bit exp_valid;

  // Reference table: {base, length, attr} per rule, attr = {lock, idem, exec, cached, valid}
  logic [AW-1:0] m_base [NR];
  logic [AW-1:0] m_len  [NR];
  logic [4:0]    m_attr [NR];

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = '0; m_len[i] = '0; m_attr[i] = '0;
    end
    m_base[0] = 64'h8000_0000; m_len[0] = 64'h4000_0000; m_attr[0] = 5'b01111;
    m_base[1] = 64'h4000_0000; m_len[1] = 64'h1000;      m_attr[1] = 5'b00001;
    m_base[2] = 64'h3000_0000; m_len[2] = 64'h1_0000;    m_attr[2] = 5'b00001;
    m_base[3] = 64'h2000_0000; m_len[3] = 64'h80_0000;   m_attr[3] = 5'b00001;
    m_base[4] = 64'h1800_0000; m_len[4] = 64'h1000;      m_attr[4] = 5'b00001;
    m_base[5] = 64'h1000_0000; m_len[5] = 64'h1000;      m_attr[5] = 5'b00001;
    m_base[6] = 64'h0C00_0000; m_len[6] = 64'h3FF_FFFF;  m_attr[6] = 5'b00001;
    m_base[7] = 64'h0200_0000; m_len[7] = 64'hC_0000;    m_attr[7] = 5'b00001;
    m_base[8] = 64'h0001_0000; m_len[8] = 64'h1_0000;    m_attr[8] = 5'b00101;
    m_base[9] = 64'h0;         m_len[9] = 64'h1000;      m_attr[9] = 5'b00101;
  endtask

  // Response word: {hit, idx, cached, exec, idem, err}
  function automatic logic [W-1:0] model_lookup(input logic [AW-1:0] a, input logic [1:0] k);
    logic [AW-1:0] off;
    for (int i = 0; i < NR; i++) begin
      off = a - m_base[i];
      if (m_attr[i][0] && m_len[i] != 0 && off < m_len[i])
        return {1'b1, i[IW-1:0], m_attr[i][1], m_attr[i][2], m_attr[i][3],
                (k == 2'd2) && !m_attr[i][2]};
    end
    return {1'b0, {IW{1'b0}}, 3'b000, 1'b1};
  endfunction

  function automatic bit model_write(input int idx, input logic [1:0] f, input logic [AW-1:0] d);
    if (idx >= NR || f == 2'd3) return 1'b1;
    if (LOCK_EN && m_attr[idx][4]) return 1'b1;
    case (f)
      2'd0: m_base[idx] = d;
      2'd1: m_len[idx]  = d;
      default: m_attr[idx] = LOCK_EN ? d[4:0] : {1'b0, d[3:0]};
    endcase
    return 1'b0;
  endfunction

  // One clock of stimulus; model bookkeeping happens at the negedge before the sampling edge.
  task automatic cycle(input bit v, input logic [AW-1:0] a, input logic [1:0] k,
                       input bit we, input int ci, input logic [1:0] cf,
                       input logic [AW-1:0] wd, input bit rdy);
    bit acc, rej;
    req_valid_i = v; req_addr_i = a; req_kind_i = k;
    cfg_we_i = we; cfg_idx_i = ci[IW-1:0]; cfg_field_i = cf; cfg_wdata_i = wd;
    resp_ready_i = rdy;
    @(negedge clk);
    chk("req_ready", req_ready_o, !exp_valid || rdy);
    acc = v && (!exp_valid || rdy);
    if (acc) exp_q.push_back(model_lookup(a, k));
    rej = we ? model_write(ci, cf, wd) : 1'b0;
    exp_valid = acc || (exp_valid && !rdy);
    @(posedge clk); #1;
    chk("resp_valid", resp_valid_o, exp_valid);
    chk("cfg_err", cfg_err_o, rej);
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [1:0] k);
    cycle(1, a, k, 0, 0, 0, 0, 1);
  endtask

  task automatic cfg_wr(input int ci, input logic [1:0] cf, input logic [AW-1:0] wd);
    cycle(0, 0, 0, 1, ci, cf, wd, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid_i = 0; cfg_we_i = 0; resp_ready_i = 0;
    #2;
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_word", {resp_hit_o, resp_idx_o, resp_cached_o, resp_exec_o, resp_idem_o, resp_err_o}, 0);
    chk("rst_cfg_err", cfg_err_o, 0);
    exp_q.delete();
    exp_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    logic [AW-1:0] l;
    if ($urandom_range(0, 7) == 0) return {$urandom, $urandom};
    r = $urandom_range(0, NR - 1);
    l = m_len[r];
    case ($urandom_range(0, 3))
      0: return m_base[r];
      1: return m_base[r] + l - 1;
      2: return m_base[r] + l;
      default: return (l == 0) ? m_base[r] : m_base[r] + ({$urandom, $urandom} % l);
    endcase
  endfunction

  // Monitor: pops on every response handshake and checks hold-stability while stalled.
  logic [W-1:0] snap, act_w;
  bit snap_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      snap_v = 1'b0;
    end else begin
      act_w = {resp_hit_o, resp_idx_o, resp_cached_o, resp_exec_o, resp_idem_o, resp_err_o};
      if (snap_v) begin
        chk("stall_valid_hold", resp_valid_o, 1);
        chk("stall_stable", act_w, snap);
      end
      if (resp_valid_o && resp_ready_i) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp_word", act_w, exp_q.pop_front());
      end
      snap_v = resp_valid_o && !resp_ready_i;
      snap = act_w;
    end
  end

  initial begin
    req_valid_i = 0; req_addr_i = 0; req_kind_i = 0; resp_ready_i = 0;
    cfg_we_i = 0; cfg_idx_i = 0; cfg_field_i = 0; cfg_wdata_i = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_dut();

    lookup(64'h8000_1000, 2'd0);
    lookup(64'h1000_0004, 2'd2);
    lookup(64'h5000_0000, 2'd0);
    lookup(64'h0001_0004, 2'd2);
    lookup(64'h0000_0ffc, 2'd3);

    cfg_wr(10, 2'd0, 64'h8000_0000);
    cfg_wr(10, 2'd1, 64'h1000);
    cfg_wr(10, 2'd2, 64'h1);
    lookup(64'h8000_0800, 2'd0);
    cfg_wr(0, 2'd2, 64'h0);
    lookup(64'h8000_0800, 2'd1);
    lookup(64'h8000_1800, 2'd0);

    cfg_wr(11, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
    cfg_wr(11, 2'd1, 64'h2000);
    cfg_wr(11, 2'd2, 64'h5);
    lookup(64'hFFFF_FFFF_FFFF_F800, 2'd2);
    lookup(64'h0000_0000_0000_0800, 2'd0);
    lookup(64'h0000_0000_0000_0fff, 2'd0);

    cycle(1, 64'h1000_0000, 2'd0, 0, 0, 0, 0, 0);
    cycle(1, 64'h4000_0000, 2'd1, 0, 0, 0, 0, 0);
    cycle(1, 64'h3000_0000, 2'd2, 0, 0, 0, 0, 0);
    cycle(1, 64'h2000_0000, 2'd0, 0, 0, 0, 0, 0);
    cycle(1, 64'h1800_0000, 2'd0, 0, 0, 0, 0, 1);
    cycle(1, 64'h0200_0000, 2'd0, 0, 0, 0, 0, 1);
    cycle(1, 64'h0C00_0000, 2'd2, 0, 0, 0, 0, 1);

    cfg_wr(NR, 2'd0, 64'h0);
    cfg_wr(5, 2'd3, 64'h0);
    lookup(64'h1000_0004, 2'd0);

`ifdef SOC_AMU_LOCK_EN
    cfg_wr(5, 2'd2, 64'h13);
    cfg_wr(5, 2'd0, 64'h0);
    cfg_wr(5, 2'd2, 64'h0);
    lookup(64'h1000_0004, 2'd0);
    lookup(64'h0000_0004, 2'd0);
    reset_dut();
    cfg_wr(5, 2'd0, 64'h0);
    lookup(64'h0000_0004, 2'd0);
    reset_dut();
`endif

    cycle(1, 64'h4000_0000, 2'd0, 1, 1, 2'd1, 64'h0, 1);
    lookup(64'h4000_0000, 2'd0);

    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        cycle(1, rand_addr(), 2'd0, 0, 0, 0, 0, 0);
        reset_dut();
      end
      if ($urandom_range(0, 19) == 0) begin
        logic [AW-1:0] wd;
        int ci;
        logic [1:0] cf;
        ci = $urandom_range(0, 15);
        cf = 2'($urandom_range(0, 3));
        case (cf)
          2'd0: wd = ($urandom_range(0, 1) == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
          2'd1: wd = ($urandom_range(0, 3) == 0) ? 64'h0 : 64'($urandom_range(1, 32'h20000));
          default: wd = 64'($urandom_range(0, 31));
        endcase
        cycle($urandom_range(0, 1) == 1, rand_addr(), 2'($urandom_range(0, 3)),
              1, ci, cf, wd, $urandom_range(0, 3) != 0);
      end else begin
        cycle($urandom_range(0, 3) != 0, rand_addr(), 2'($urandom_range(0, 3)),
              0, 0, 0, 0, $urandom_range(0, 3) != 0);
      end
    end

    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    chk("drain_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
